matrix_mac_engine: RTL and testbench

- Downstream consumer of the two matrix_ram instances that hold operand matrices A and B; computes C = A x B one element at a time.
- Drives the RAMs' active-low read-side controls and address, multiply-accumulates the returned words, and streams each C element out over a valid/ready handshake to the result sink.
- Start/busy/done control interface toward the top-level sequencer.

---
 rtl/matrix_mac_engine.sv | 189 ++++++++++++++++++
 tb/tb_matrix_mac_engine.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_mac_engine.sv
// ---------------------------------------------------------------------------
// matrix_mac_engine
//
// Computes C = A x B for two N x N unsigned matrices (N = 2**DIM_BITS) held
// in two external single-port RAMs with one cycle of read latency. Each
// element C[i][j] is formed by N reads of A[i][k] and B[k][j], a multiply-
// accumulate pipeline, and a valid/ready handshake toward the result sink.
// Elements leave in row-major order.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             one-cycle request to run a full multiply (IDLE only)
//   busy              high while a multiply is in progress
//   done              one-cycle pulse after the last element is accepted
//   a_enable_n        RAM A chip enable (active low)
//   a_wren_n          RAM A write enable (active low), tied inactive
//   a_address         RAM A address {row, col}
//   a_out             RAM A read data, one cycle after the address
//   b_enable_n        RAM B chip enable (active low)
//   b_wren_n          RAM B write enable (active low), tied inactive
//   b_address         RAM B address {row, col}
//   b_out             RAM B read data, one cycle after the address
//   c_valid, c_ready  result handshake
//   c_data            C[c_row][c_col]
//   c_row, c_col      coordinates of the element on c_data
// ---------------------------------------------------------------------------
module matrix_mac_engine #(
    parameter int DATA_WIDTH   = 8,
    parameter int DIM_BITS     = 2,
    parameter int ADDRESS_BITS = 2 * DIM_BITS,
    parameter int ACC_WIDTH    = 2 * DATA_WIDTH + DIM_BITS
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    start,
    output logic                    busy,
    output logic                    done,

    output logic                    a_enable_n,
    output logic                    a_wren_n,
    output logic [ADDRESS_BITS-1:0] a_address,
    input  logic [DATA_WIDTH-1:0]   a_out,

    output logic                    b_enable_n,
    output logic                    b_wren_n,
    output logic [ADDRESS_BITS-1:0] b_address,
    input  logic [DATA_WIDTH-1:0]   b_out,

    output logic                    c_valid,
    input  logic                    c_ready,
    output logic [ACC_WIDTH-1:0]    c_data,
    output logic [DIM_BITS-1:0]     c_row,
    output logic [DIM_BITS-1:0]     c_col
);

    // Highest index along any dimension (N-1).
    localparam logic [DIM_BITS-1:0] IDX_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE,   // waiting for start
        S_READ,   // issuing N reads for the current element
        S_DRAIN,  // absorbing the product of the last read
        S_OUT,    // presenting C[i][j] until the sink accepts it
        S_DONE    // one-cycle completion pulse
    } state_t;

    state_t                  state_q, state_d;
    logic [DIM_BITS-1:0]     i_q, i_d;     // row of C
    logic [DIM_BITS-1:0]     j_q, j_d;     // column of C
    logic [DIM_BITS-1:0]     k_q, k_d;     // inner-product index
    logic [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic                    rd_q, rd_d;   // a read was issued last cycle

    logic [2*DATA_WIDTH-1:0] product;

    // Full-width unsigned product; N products of at most (2**DW-1)**2 fit in
    // ACC_WIDTH, so the accumulator cannot overflow.
    assign product = a_out * b_out;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: state uses non-blocking assignments so every flop samples the
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            rd_q    <= rd_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every signal gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        rd_d    = (state_q == S_READ);
        acc_d   = acc_q;

        // Read data returns one cycle after the address, so the product
        // belongs to the read issued in the previous cycle.
        if (rd_q) begin
            acc_d = acc_q + ACC_WIDTH'(product);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_READ;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                end
            end

            S_READ: begin
                k_d = k_q + 1'b1;  // wraps to 0 after the last inner index
                if (k_q == IDX_LAST) begin
                    state_d = S_DRAIN;
                end
            end

            S_DRAIN: begin
                state_d = S_OUT;
            end

            S_OUT: begin
                if (c_ready) begin
                    acc_d = '0;
                    j_d   = j_q + 1'b1;
                    if (j_q == IDX_LAST) begin
                        i_d = i_q + 1'b1;
                    end
                    if ((i_q == IDX_LAST) && (j_q == IDX_LAST)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs, decoded from registered state so they are glitch-free
    // -----------------------------------------------------------------------
    assign busy       = (state_q == S_READ) || (state_q == S_DRAIN) || (state_q == S_OUT);
    assign done       = (state_q == S_DONE);

    assign a_enable_n = (state_q != S_READ);
    assign b_enable_n = (state_q != S_READ);
    assign a_wren_n   = 1'b1;
    assign b_wren_n   = 1'b1;
    assign a_address  = {i_q, k_q};
    assign b_address  = {k_q, j_q};

    // The accumulator is idle during OUT, so c_data holds while stalled.
    assign c_valid    = (state_q == S_OUT);
    assign c_data     = acc_q;
    assign c_row      = i_q;
    assign c_col      = j_q;

endmodule

// File: tb/tb_matrix_mac_engine.sv
// ---------------------------------------------------------------------------
// tb_matrix_mac_engine
//
// Drives matrix_mac_engine with behavioural RAMs for A and B. Expected C
// elements and expected RAM address pairs are computed from plain matrix
// arithmetic and queued when a run starts; monitor processes pop and compare
// whenever the DUT hands over an element or issues a read.
// ---------------------------------------------------------------------------
module tb_matrix_mac_engine;

    localparam int DW  = 8;
    localparam int DB  = 2;
    localparam int AB  = 2 * DB;
    localparam int AW  = 2 * DW + DB;
    localparam int N   = 1 << DB;
    localparam int NN  = N * N;

    // Edges from the start-sampling edge to the first c_valid and to done.
    localparam int FIRST_LAT = N + 1;
    localparam int DONE_LAT  = NN * (N + 2);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done;
    logic          a_enable_n, a_wren_n, b_enable_n, b_wren_n;
    logic [AB-1:0] a_address, b_address;
    logic [DW-1:0] a_out = '0;
    logic [DW-1:0] b_out = '0;
    logic          c_valid;
    logic          c_ready = 1'b1;
    logic [AW-1:0] c_data;
    logic [DB-1:0] c_row, c_col;

    matrix_mac_engine #(
        .DATA_WIDTH (DW),
        .DIM_BITS   (DB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .a_enable_n (a_enable_n),
        .a_wren_n   (a_wren_n),
        .a_address  (a_address),
        .a_out      (a_out),
        .b_enable_n (b_enable_n),
        .b_wren_n   (b_wren_n),
        .b_address  (b_address),
        .b_out      (b_out),
        .c_valid    (c_valid),
        .c_ready    (c_ready),
        .c_data     (c_data),
        .c_row      (c_row),
        .c_col      (c_col)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Operand RAMs: registered read, one cycle latency
    // ------------------------------------------------------------------
    int unsigned a_mem [NN];
    int unsigned b_mem [NN];

    always @(posedge clk) begin
        if (!a_enable_n && a_wren_n) a_out <= DW'(a_mem[a_address]);
        if (!b_enable_n && b_wren_n) b_out <= DW'(b_mem[b_address]);
    end

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        int      row;
        int      col;
        longint  data;
    } c_exp_t;

    c_exp_t c_q [$];
    int     addr_q [$];      // a_address * 256 + b_address

    int     start_cyc     = 0;
    bit     timing_en     = 1'b0;
    bit     first_pending = 1'b0;
    int     done_count    = 0;
    bit     wren_seen_low = 1'b0;
    bit     en_mismatch   = 1'b0;
    bit     en_outside    = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitors (sample on the falling edge, away from the active edge)
    // ------------------------------------------------------------------
    bit            stalled_prev = 1'b0;
    logic [AW-1:0] held_data;
    logic [DB-1:0] held_row, held_col;

    always @(negedge clk) begin
        if (rst) begin
            stalled_prev = 1'b0;
        end else begin
            if (!a_wren_n || !b_wren_n) wren_seen_low = 1'b1;
            if (a_enable_n != b_enable_n) en_mismatch = 1'b1;
            if (!a_enable_n && (c_valid || done || !busy)) en_outside = 1'b1;

            // Read addresses
            if (!a_enable_n) begin
                if (addr_q.size() == 0) begin
                    check("read_unexpected", 1, 0);
                end else begin
                    int exp_pair;
                    exp_pair = addr_q.pop_front();
                    check("read_addr_pair", int'(a_address) * 256 + int'(b_address), exp_pair);
                end
            end

            // Result stream
            if (c_valid && first_pending) begin
                first_pending = 1'b0;
                check("first_valid_busy", busy, 1);
                if (timing_en) check("first_valid_cycle", cyc, start_cyc + FIRST_LAT);
            end
            if (c_valid && stalled_prev) begin
                check("stall_hold", {c_data, c_row, c_col}, {held_data, held_row, held_col});
            end
            if (c_valid && c_ready) begin
                if (c_q.size() == 0) begin
                    check("c_unexpected", 1, 0);
                end else begin
                    c_exp_t e;
                    e = c_q.pop_front();
                    check("c_data", c_data, e.data);
                    check("c_row_col", int'(c_row) * 16 + int'(c_col), e.row * 16 + e.col);
                end
            end
            stalled_prev = c_valid && !c_ready;
            held_data    = c_data;
            held_row     = c_row;
            held_col     = c_col;

            if (done) begin
                done_count++;
                check("done_busy_low", busy, 0);
                if (timing_en) check("done_cycle", cyc, start_cyc + DONE_LAT);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic load(input int pat);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                case (pat)
                    0: begin a_mem[r*N+c] = (r == c) ? 1 : 0; b_mem[r*N+c] = r * N + c + 1; end
                    1: begin a_mem[r*N+c] = 255;              b_mem[r*N+c] = 255;            end
                    2: begin a_mem[r*N+c] = r + 1;            b_mem[r*N+c] = c + 1;          end
                    3: begin a_mem[r*N+c] = 0;                b_mem[r*N+c] = 0;              end
                    default: begin
                        a_mem[r*N+c] = $urandom_range(0, 255);
                        b_mem[r*N+c] = $urandom_range(0, 255);
                    end
                endcase
            end
        end
    endtask

    // Reference: C = A x B by the textbook triple loop, plus the read order.
    task automatic predict();
        c_q.delete();
        addr_q.delete();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                c_exp_t e;
                longint sum;
                sum = 0;
                for (int k = 0; k < N; k++) begin
                    sum += longint'(a_mem[i*N+k]) * longint'(b_mem[k*N+j]);
                    addr_q.push_back((i * N + k) * 256 + (k * N + j));
                end
                e.row  = i;
                e.col  = j;
                e.data = sum;
                c_q.push_back(e);
            end
        end
    endtask

    task automatic drive_ready(input int rmode);
        case (rmode)
            0:       c_ready = 1'b1;
            1:       c_ready = ((cyc / 3) % 2) == 1;
            default: c_ready = ($urandom_range(0, 2) != 0);
        endcase
    endtask

    // One full multiply. rmode: 0 ready high, 1 toggle every 3 cycles,
    // 2 random. abort_at > 0 asserts rst that many edges after start.
    task automatic run(input int pat, input int rmode, input bit extra, input int abort_at);
        int done0;
        load(pat);
        predict();
        timing_en = (rmode == 0);
        drive_ready(rmode);
        start = 1'b1;
        start_cyc = cyc + 1;
        first_pending = 1'b1;
        done0 = done_count;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (done_count != done0) break;
            if (abort_at > 0 && cyc == start_cyc + abort_at) begin
                #1;
                rst = 1'b1;
                #1;
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_c_valid", c_valid, 0);
                check("rst_c_data", c_data, 0);
                check("rst_c_row_col", {c_row, c_col}, 0);
                check("rst_enables_n", {a_enable_n, b_enable_n}, 2'b11);
                check("rst_addresses", {a_address, b_address}, 0);
                c_q.delete();
                addr_q.delete();
                first_pending = 1'b0;
                c_ready = 1'b1;
                repeat (3) @(posedge clk);
                #1 rst = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                check("abort_no_done", done_count, done0);
                return;
            end
            drive_ready(rmode);
            start = extra && ((cyc + 1 == start_cyc + 10) || (cyc + 1 == start_cyc + 50));
            @(posedge clk); #1;
        end
        start = 1'b0;
        c_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("done_count", done_count - done0, 1);
        check("c_all_seen", c_q.size(), 0);
        check("reads_all_seen", addr_q.size(), 0);
        check("idle_after_done", busy, 0);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_c_valid", c_valid, 0);
        check("reset_outputs", {c_data, c_row, c_col}, 0);
        check("reset_enables_n", {a_enable_n, b_enable_n, a_wren_n, b_wren_n}, 4'b1111);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        run(0, 0, 1'b0, 0);   // identity x (1..16), exact latency
        run(1, 0, 1'b0, 0);   // all 255: widest products
        run(2, 1, 1'b0, 0);   // outer-product pattern with stalls
        run(0, 0, 1'b1, 0);   // extra start pulses are ignored
        run(4, 0, 1'b0, 30);  // aborted mid-READ by reset
        run(4, 0, 1'b0, 0);   // fresh run after reset from C[0][0]
        run(3, 0, 1'b0, 0);   // zero matrices, address order
        for (int t = 0; t < 3; t++) begin
            run(4, 2, 1'b0, 0);  // random data, random back-pressure
        end

        check("wren_never_low", wren_seen_low, 0);
        check("enables_matched", en_mismatch, 0);
        check("enables_only_in_read", en_outside, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
